// File: rtl/ctrl_pipe_if.sv
// Control bundle between the decoder (master) and the ctrl_pipe pipeline registers (slave).
// Carries decoded ID-stage control in, and stage control, stall and stall count back out.
interface ctrl_pipe_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic                  id_reg_write;
    logic                  id_alu_src;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic                  id_mem_read;
    logic                  id_mem_to_reg;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  flush;
    logic                  stall;
    logic                  ex_valid;
    logic                  ex_alu_src;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_dst;
    logic                  mem_valid;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_reg_write, id_alu_src, id_alu_op, id_mem_read, id_mem_to_reg,
        output id_rs, id_rt, id_dst, flush,
        input  stall, ex_valid, ex_alu_src, ex_alu_op, ex_dst,
        input  mem_valid, mem_read, mem_dst,
        input  wb_reg_write, wb_mem_to_reg, wb_dst, stall_count
    );

    modport slave (
        input  id_valid, id_reg_write, id_alu_src, id_alu_op, id_mem_read, id_mem_to_reg,
        input  id_rs, id_rt, id_dst, flush,
        output stall, ex_valid, ex_alu_src, ex_alu_op, ex_dst,
        output mem_valid, mem_read, mem_dst,
        output wb_reg_write, wb_mem_to_reg, wb_dst, stall_count
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline with load-use hazard detection, bubble insertion
// and a saturating stall counter.
module ctrl_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus
);
    logic                  ex_valid_q, ex_valid_d;
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic                  ex_alu_src_q, ex_alu_src_d;
    logic [ALU_OP_W-1:0]   ex_alu_op_q, ex_alu_op_d;
    logic                  ex_mem_read_q, ex_mem_read_d;
    logic                  ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;

    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_reg_write_q, mem_reg_write_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;

    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;

    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic                  src_match;
    logic                  hazard;
    logic                  bubble;

    // A load in EX whose destination feeds a real source of the ID instruction must wait one cycle.
    always_comb begin
        src_match = (ex_dst_q == bus.id_rs) ||
                    ((ex_dst_q == bus.id_rt) && !bus.id_alu_src);
        hazard    = bus.id_valid && ex_valid_q && ex_mem_read_q &&
                    (ex_dst_q != '0) && !bus.flush && src_match;
        bubble    = hazard || bus.flush || !bus.id_valid;
    end

    always_comb begin
        ex_valid_d      = 1'b0;
        ex_reg_write_d  = 1'b0;
        ex_alu_src_d    = 1'b0;
        ex_alu_op_d     = '0;
        ex_mem_read_d   = 1'b0;
        ex_mem_to_reg_d = 1'b0;
        ex_dst_d        = '0;
        if (!bubble) begin
            ex_valid_d      = 1'b1;
            ex_reg_write_d  = bus.id_reg_write;
            ex_alu_src_d    = bus.id_alu_src;
            ex_alu_op_d     = bus.id_alu_op;
            ex_mem_read_d   = bus.id_mem_read;
            ex_mem_to_reg_d = bus.id_mem_to_reg;
            ex_dst_d        = bus.id_dst;
        end

        mem_valid_d     = ex_valid_q;
        mem_reg_write_d = ex_reg_write_q;
        mem_read_d      = ex_mem_read_q;
        mem_to_reg_d    = ex_mem_to_reg_q;
        mem_dst_d       = ex_dst_q;

        wb_valid_d      = mem_valid_q;
        wb_reg_write_d  = mem_reg_write_q;
        wb_mem_to_reg_d = mem_to_reg_q;
        wb_dst_d        = mem_dst_q;

        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Reset discards every in-flight instruction so nothing writes back after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_alu_op_q     <= '0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_dst_q        <= '0;
            mem_valid_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            mem_dst_q       <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_dst_q        <= '0;
            stall_count_q   <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_dst_q        <= ex_dst_d;
            mem_valid_q     <= mem_valid_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_read_q      <= mem_read_d;
            mem_to_reg_q    <= mem_to_reg_d;
            mem_dst_q       <= mem_dst_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_dst_q        <= wb_dst_d;
            stall_count_q   <= stall_count_d;
        end
    end

    // Register $zero is hard-wired, so a write to it is suppressed at WB.
    assign bus.stall         = hazard;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_alu_src    = ex_valid_q & ex_alu_src_q;
    assign bus.ex_alu_op     = ex_alu_op_q & {ALU_OP_W{ex_valid_q}};
    assign bus.ex_dst        = ex_dst_q;
    assign bus.mem_valid     = mem_valid_q;
    assign bus.mem_read      = mem_valid_q & mem_read_q;
    assign bus.mem_dst       = mem_dst_q;
    assign bus.wb_reg_write  = wb_valid_q & wb_reg_write_q & (wb_dst_q != '0);
    assign bus.wb_mem_to_reg = wb_valid_q & wb_mem_to_reg_q;
    assign bus.wb_dst        = wb_dst_q;
    assign bus.stall_count   = stall_count_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe: reset, issue timing, load-use stalls,
// flush priority and counter saturation on a narrow-counter build.
module tb_ctrl_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ctrl_pipe_if #(.REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(16)) bus ();
    ctrl_pipe_if #(.REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(2))  bus2 ();

    ctrl_pipe #(.REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    ctrl_pipe #(.REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic asrc,
                                 input logic [1:0] op, input logic mr, input logic m2r,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] dst, input logic fl);
        bus.id_valid      = v;
        bus.id_reg_write  = rw;
        bus.id_alu_src    = asrc;
        bus.id_alu_op     = op;
        bus.id_mem_read   = mr;
        bus.id_mem_to_reg = m2r;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_dst        = dst;
        bus.flush         = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        bus2.id_valid = 1'b0; bus2.id_reg_write = 1'b0; bus2.id_alu_src = 1'b0;
        bus2.id_alu_op = 2'b00; bus2.id_mem_read = 1'b0; bus2.id_mem_to_reg = 1'b0;
        bus2.id_rs = 5'd0; bus2.id_rt = 5'd0; bus2.id_dst = 5'd0; bus2.flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("reset_stall_count", 32'(bus.stall_count), 32'd0);
        checkOutput("reset_ex_valid", 32'(bus.ex_valid), 32'd0);

        // Fill every stage, then pull reset asynchronously mid-cycle
        applyStimulus(1, 1, 0, 2'b10, 0, 0, 5'd1, 5'd2, 5'd7, 0);
        tick();
        tick();
        tick();
        checkOutput("full_wb_reg_write", 32'(bus.wb_reg_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("async_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        checkOutput("async_rst_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("post_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        checkOutput("post_rst_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        checkOutput("post_rst_wb_dst", 32'(bus.wb_dst), 32'd0);
        checkOutput("post_rst_stall", 32'(bus.stall), 32'd0);

        // R-type dst=8 travels EX -> MEM -> WB on consecutive edges
        applyStimulus(1, 1, 0, 2'b10, 0, 0, 5'd1, 5'd2, 5'd8, 0);
        tick();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        checkOutput("rtype_ex_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("rtype_ex_alu_op", 32'(bus.ex_alu_op), 32'd2);
        checkOutput("rtype_ex_dst", 32'(bus.ex_dst), 32'd8);
        tick();
        checkOutput("rtype_mem_dst", 32'(bus.mem_dst), 32'd8);
        checkOutput("rtype_mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("rtype_wb_reg_write_early", 32'(bus.wb_reg_write), 32'd0);
        tick();
        checkOutput("rtype_wb_reg_write", 32'(bus.wb_reg_write), 32'd1);
        checkOutput("rtype_wb_dst", 32'(bus.wb_dst), 32'd8);
        checkOutput("rtype_wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'd0);

        // lw r9 followed by add using rs=9: one stall, one bubble
        applyStimulus(1, 1, 1, 2'b00, 1, 1, 5'd1, 5'd9, 5'd9, 0);
        tick();
        applyStimulus(1, 1, 0, 2'b10, 0, 0, 5'd9, 5'd3, 5'd10, 0);
        #1;
        checkOutput("lu_stall_on", 32'(bus.stall), 32'd1);
        tick();
        checkOutput("lu_ex_bubble", 32'(bus.ex_valid), 32'd0);
        checkOutput("lu_stall_count", 32'(bus.stall_count), 32'd1);
        checkOutput("lu_mem_read", 32'(bus.mem_read), 32'd1);
        checkOutput("lu_mem_dst", 32'(bus.mem_dst), 32'd9);
        checkOutput("lu_stall_off", 32'(bus.stall), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        checkOutput("lu_add_ex_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("lu_add_ex_dst", 32'(bus.ex_dst), 32'd10);
        checkOutput("lu_wb_dst", 32'(bus.wb_dst), 32'd9);
        checkOutput("lu_wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'd1);

        // rt match only counts when rt is a real source; $zero never stalls
        applyStimulus(1, 1, 1, 2'b00, 1, 1, 5'd1, 5'd9, 5'd9, 0);
        tick();
        applyStimulus(1, 1, 0, 2'b00, 1, 1, 5'd4, 5'd9, 5'd11, 0);
        #1;
        checkOutput("rt_src_stall", 32'(bus.stall), 32'd1);
        applyStimulus(1, 1, 1, 2'b00, 1, 1, 5'd4, 5'd9, 5'd11, 0);
        #1;
        checkOutput("rt_imm_no_stall", 32'(bus.stall), 32'd0);
        tick();
        checkOutput("rt_imm_ex_dst", 32'(bus.ex_dst), 32'd11);
        applyStimulus(1, 1, 1, 2'b00, 1, 1, 5'd1, 5'd0, 5'd0, 0);
        tick();
        applyStimulus(1, 1, 0, 2'b10, 0, 0, 5'd0, 5'd5, 5'd12, 0);
        #1;
        checkOutput("zero_no_stall", 32'(bus.stall), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        checkOutput("zero_add_ex_valid", 32'(bus.ex_valid), 32'd1);
        tick();
        checkOutput("zero_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        checkOutput("zero_wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'd1);
        checkOutput("zero_stall_count", 32'(bus.stall_count), 32'd1);

        // Flush wins over a simultaneous load-use hazard
        applyStimulus(1, 1, 1, 2'b00, 1, 1, 5'd1, 5'd12, 5'd12, 0);
        tick();
        applyStimulus(1, 1, 0, 2'b10, 0, 0, 5'd12, 5'd3, 5'd13, 1);
        #1;
        checkOutput("flush_stall", 32'(bus.stall), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        checkOutput("flush_ex_bubble", 32'(bus.ex_valid), 32'd0);
        checkOutput("flush_stall_count", 32'(bus.stall_count), 32'd1);
        tick();
        tick();
        checkOutput("flush_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        checkOutput("flush_wb_dst", 32'(bus.wb_dst), 32'd0);

        // Narrow counter: a self-dependent load stalls every other cycle
        bus2.id_valid = 1'b1; bus2.id_reg_write = 1'b1; bus2.id_alu_src = 1'b1;
        bus2.id_mem_read = 1'b1; bus2.id_mem_to_reg = 1'b1;
        bus2.id_rs = 5'd5; bus2.id_rt = 5'd5; bus2.id_dst = 5'd5;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("sat_count_2", 32'(bus2.stall_count), 32'd2);
        tick();
        tick();
        checkOutput("sat_count_3", 32'(bus2.stall_count), 32'd3);
        tick();
        checkOutput("sat_stall_pending", 32'(bus2.stall), 32'd1);
        tick();
        checkOutput("sat_hold_a", 32'(bus2.stall_count), 32'd3);
        tick();
        tick();
        checkOutput("sat_hold_b", 32'(bus2.stall_count), 32'd3);
        bus2.id_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
